bcd_countdown_timer: RTL and testbench

Parametrised multi-digit BCD countdown timer for game-round and turn timing. It replaces per-digit cascaded counters with one block that holds DIGITS BCD nibbles and decrements them with an internal borrow chain. Run, pause and done control is handled by a small state machine, with optional auto-reload for repeating periods. It sits between the tick-strobe generator and the seven-segment display and game-control logic.

---
 rtl/bcd_countdown_timer.sv | 118 +++++++++++
 tb/tb_bcd_countdown_timer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with run/pause/done control.
// Optional auto-reload gives repeating periods of the loaded length.
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  input  logic                  reload_en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  expired,
  output logic                  zero
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   reload;
  logic [W-1:0]   sat_val;
  logic [W-1:0]   dec_val;
  logic           is_one;

  always_comb begin
    sat_val = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9)
        sat_val[4*i +: 4] = 4'd9;
    end
  end

  // Borrow ripples upward: a zero digit becomes 9 and keeps borrowing.
  always_comb begin
    logic borrow;
    dec_val = count;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign is_one  = (count == W'(1));
  assign zero    = (count == '0);
  assign running = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        count  <= '0;
        reload <= '0;
      end else if (load) begin
        state  <= IDLE;
        count  <= sat_val;
        reload <= sat_val;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !zero)
              state <= RUN;
          end
          RUN: begin
            if (pause) begin
              state <= PAUSE;
            end else if (tick && !zero) begin
              if (is_one) begin
                expired <= 1'b1;
                if (reload_en && reload != '0) begin
                  count <= reload;
                end else begin
                  count <= '0;
                  state <= DONE;
                end
              end else begin
                count <= dec_val;
              end
            end
          end
          PAUSE: begin
            if (start)
              state <= RUN;
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with DIGITS = 4.
// Each step drives inputs, advances one clock and checks outputs.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, load, start, pause, tick, reload_en;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        running, done, expired, zero;

  int errors = 0;
  int checks = 0;
  int pulses;

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .pause     (pause),
    .tick      (tick),
    .reload_en (reload_en),
    .count     (count),
    .running   (running),
    .done      (done),
    .expired   (expired),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clear = 0; load = 0; start = 0; pause = 0; tick = 0;
  endtask

  initial begin
    rst = 0; clear = 0; load = 0; start = 0; pause = 0;
    tick = 0; reload_en = 0; load_val = '0;
    #12;
    chk("rst_count", count, 16'h0000);
    chk("rst_zero", 16'(zero), 16'd1);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_running", 16'(running), 16'd0);
    chk("rst_expired", 16'(expired), 16'd0);
    @(negedge clk);
    rst = 1;
    cyc();

    load = 1; load_val = 16'h0105; cyc();
    chk("load_0105", count, 16'h0105);
    chk("load_idle", 16'(running), 16'd0);

    // borrow chain
    load = 1; load_val = 16'h1000; cyc();
    start = 1; cyc();
    chk("start_run", 16'(running), 16'd1);
    tick = 1; cyc();
    chk("borrow_0999", count, 16'h0999);
    pulses = 0;
    for (int i = 0; i < 998; i++) begin
      tick = 1; cyc();
      if (expired) pulses++;
    end
    chk("cnt_0001", count, 16'h0001);
    tick = 1; cyc();
    if (expired) pulses++;
    chk("exp_zero", count, 16'h0000);
    chk("exp_pulse", 16'(expired), 16'd1);
    chk("exp_done", 16'(done), 16'd1);
    chk("exp_notrun", 16'(running), 16'd0);
    tick = 1; start = 1; cyc();
    if (expired) pulses++;
    chk("done_hold", count, 16'h0000);
    chk("done_stay", 16'(done), 16'd1);
    chk("pulse_once", 16'(pulses), 16'd1);

    // saturation and start at zero
    load = 1; load_val = 16'hA3F0; cyc();
    chk("sat_9390", count, 16'h9390);
    chk("load_exit_done", 16'(done), 16'd0);
    load = 1; load_val = 16'h0000; cyc();
    start = 1; cyc();
    chk("zstart_idle", 16'(running), 16'd0);
    chk("zstart_noexp", 16'(expired), 16'd0);
    tick = 1; cyc();
    chk("zstart_noexp2", 16'(expired), 16'd0);
    chk("zstart_cnt", count, 16'h0000);

    // pause and priorities
    load = 1; load_val = 16'h0010; cyc();
    start = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      tick = 1; cyc();
    end
    chk("cnt_0007", count, 16'h0007);
    pause = 1; tick = 1; cyc();
    chk("pause_drop", count, 16'h0007);
    chk("pause_state", 16'(running), 16'd0);
    tick = 1; cyc();
    tick = 1; pause = 1; cyc();
    chk("pause_hold", count, 16'h0007);
    start = 1; cyc();
    chk("resume", 16'(running), 16'd1);
    tick = 1; cyc();
    chk("cnt_0006", count, 16'h0006);
    tick = 1; start = 1; cyc();
    chk("start_in_run", count, 16'h0005);
    load = 1; load_val = 16'h0042; tick = 1; cyc();
    chk("load_tick", count, 16'h0042);
    chk("load_idle2", 16'(running), 16'd0);

    // auto-reload
    reload_en = 1;
    load = 1; load_val = 16'h0003; cyc();
    start = 1; cyc();
    for (int i = 1; i <= 9; i++) begin
      tick = 1; cyc();
      chk($sformatf("rl_cnt%0d", i), count,
          (i % 3 == 0) ? 16'h0003 : 16'(3 - (i % 3)));
      chk($sformatf("rl_exp%0d", i), 16'(expired),
          (i % 3 == 0) ? 16'd1 : 16'd0);
    end
    chk("rl_running", 16'(running), 16'd1);
    cyc();
    chk("rl_exp_low", 16'(expired), 16'd0);

    // async reset mid-run
    reload_en = 0;
    load = 1; load_val = 16'h0043; cyc();
    start = 1; cyc();
    tick = 1; cyc();
    chk("pre_rst", count, 16'h0042);
    tick = 1;
    #2 rst = 0;
    #1;
    chk("arst_count", count, 16'h0000);
    chk("arst_running", 16'(running), 16'd0);
    @(posedge clk);
    #1;
    tick = 0;
    chk("arst_hold", count, 16'h0000);
    @(negedge clk);
    rst = 1;
    cyc();
    chk("arst_noexp", 16'(expired), 16'd0);
    chk("arst_idle", 16'(running), 16'd0);

    // clear
    load = 1; load_val = 16'h0005; cyc();
    start = 1; cyc();
    clear = 1; tick = 1; cyc();
    chk("clr_count", count, 16'h0000);
    chk("clr_idle", 16'(running), 16'd0);
    reload_en = 1;
    start = 1; cyc();
    chk("clr_nostart", 16'(running), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
